// File: rtl/load_store_unit.sv
// RV64I load/store unit: byte/half/word/double extraction and read-modify-write sub-doubleword stores.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses; otherwise low offset bits are aligned down.
module load_store_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic        i_req_store,
  input  logic [2:0]  i_req_funct3,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  output logic        o_req_ready,
  output logic        o_resp_valid,
  output logic [63:0] o_resp_rdata,
  output logic        o_misaligned,
  output logic [63:0] o_mem_addr,
  output logic [63:0] o_mem_wdata,
  output logic        o_mem_wr,
  input  logic [63:0] i_mem_rdata
);

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR, S_RESP} state_t;

  state_t      r_state;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [2:0]  r_off;
  logic [63:0] r_wdata;
  logic [2:0]  r_cnt;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [63:0] r_resp_rdata;
  logic        r_misaligned;
  logic [63:0] r_mem_addr;
  logic [63:0] r_mem_wdata;
  logic        r_mem_wr;

  logic [2:0]  w_lowmask;
  logic [2:0]  w_off;
  logic        w_mis;

  always_comb begin
    w_lowmask = '0;
    case (i_req_funct3[1:0])
      2'b00:   w_lowmask = 3'b000;
      2'b01:   w_lowmask = 3'b001;
      2'b10:   w_lowmask = 3'b011;
      default: w_lowmask = 3'b111;
    endcase
  end

  assign w_off = i_req_addr[2:0] & ~w_lowmask;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = |(i_req_addr[2:0] & w_lowmask);
`else
  assign w_mis = 1'b0;
`endif

  function automatic logic [63:0] f_extract(input logic [63:0] dw, input logic [2:0] off,
                                            input logic [2:0] f3);
    logic [63:0] s;
    s = dw >> {off, 3'b000};
    case (f3)
      3'b000:  return {{56{s[7]}}, s[7:0]};
      3'b001:  return {{48{s[15]}}, s[15:0]};
      3'b010:  return {{32{s[31]}}, s[31:0]};
      3'b011:  return s;
      3'b100:  return {56'd0, s[7:0]};
      3'b101:  return {48'd0, s[15:0]};
      3'b110:  return {32'd0, s[31:0]};
      default: return '0;
    endcase
  endfunction

  function automatic logic [63:0] f_merge(input logic [63:0] dw, input logic [63:0] wd,
                                          input logic [2:0] off, input logic [1:0] sz);
    logic [63:0] m;
    case (sz)
      2'b00:   m = 64'h0000_0000_0000_00FF;
      2'b01:   m = 64'h0000_0000_0000_FFFF;
      2'b10:   m = 64'h0000_0000_FFFF_FFFF;
      default: m = '1;
    endcase
    m = m << {off, 3'b000};
    return (dw & ~m) | ((wd << {off, 3'b000}) & m);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_store      <= 1'b0;
      r_funct3     <= '0;
      r_off        <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_misaligned <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wr     <= 1'b0;
    end else begin
      r_mem_wr     <= 1'b0;
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_store     <= i_req_store;
            r_funct3    <= i_req_funct3;
            r_off       <= w_off;
            r_wdata     <= i_req_wdata;
            r_mem_addr  <= {i_req_addr[63:3], 3'b000};
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            if (w_mis) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
              r_misaligned <= 1'b1;
            end else if (i_req_store && (i_req_funct3[1:0] == 2'b11)) begin
              r_state     <= S_WR;
              r_mem_wdata <= i_req_wdata;
              r_mem_wr    <= 1'b1;
            end else begin
              r_state <= S_RD_WAIT;
            end
          end
        end
        // Read data sampled once the memory pipeline has had MEM_LATENCY cycles past address launch.
        S_RD_WAIT: begin
          if (r_cnt == LAT) begin
            if (r_store) begin
              r_state     <= S_WR;
              r_mem_wdata <= f_merge(i_mem_rdata, r_wdata, r_off, r_funct3[1:0]);
              r_mem_wr    <= 1'b1;
            end else begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= f_extract(i_mem_rdata, r_off, r_funct3);
              r_misaligned <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_WR: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= '0;
          r_misaligned <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_misaligned = r_misaligned;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_wr     = r_mem_wr;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed loads/stores against a small latency-modelled memory.
module tb_load_store_unit;
  localparam int unsigned LAT = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        i_req_store = 1'b0;
  logic [2:0]  i_req_funct3 = '0;
  logic [63:0] i_req_addr = '0;
  logic [63:0] i_req_wdata = '0;
  logic        o_req_ready;
  logic        o_resp_valid;
  logic [63:0] o_resp_rdata;
  logic        o_misaligned;
  logic [63:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic        o_mem_wr;
  logic [63:0] i_mem_rdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct { logic [63:0] rdata; logic mis; int lat; int acc; } resp_t;
  typedef struct { logic [63:0] addr; logic [63:0] data; int lat; int acc; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  load_store_unit #(.MEM_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_store(i_req_store), .i_req_funct3(i_req_funct3),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_req_ready(o_req_ready), .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata),
    .o_misaligned(o_misaligned), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_wr(o_mem_wr), .i_mem_rdata(i_mem_rdata)
  );

  logic [63:0] mem [8];
  logic [63:0] pipe [LAT];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mem[0] <= 64'hF0E0D0C0_B0A09080;
      mem[1] <= 64'h11111111_11111111;
      mem[2] <= 64'h88776655_44332211;
      mem[3] <= 64'h0;
      mem[4] <= 64'h0;
      mem[5] <= 64'h0;
      mem[6] <= 64'h0;
      mem[7] <= 64'h0;
    end else if (o_mem_wr) begin
      mem[o_mem_addr[5:3]] <= o_mem_wdata;
    end
  end

  always @(posedge clock) begin
    pipe[0] <= mem[o_mem_addr[5:3]];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign i_mem_rdata = pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    resp_t r;
    wr_t   w;
    if (!reset) begin
      if (o_resp_valid) begin
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL resp_unexpected: got resp_valid=1 expected 0");
        end else begin
          r = rq.pop_front();
          chk("resp_rdata", o_resp_rdata, r.rdata);
          chk("misaligned", {63'd0, o_misaligned}, {63'd0, r.mis});
          chk("resp_latency", 64'(cyc - r.acc), 64'(r.lat));
        end
      end
      if (o_mem_wr) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL mem_wr_unexpected: got mem_wr=1 expected 0");
        end else begin
          w = wq.pop_front();
          chk("mem_addr", o_mem_addr, w.addr);
          chk("mem_wdata", o_mem_wdata, w.data);
          chk("mem_wr_latency", 64'(cyc - w.acc), 64'(w.lat));
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clock);
    while (!o_req_ready && n < 50) begin @(negedge clock); n++; end
    if (!o_req_ready) begin
      tests++; fails++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1");
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] erd, input logic emis,
                       input int elat, input logic ewr, input logic [63:0] ewaddr,
                       input logic [63:0] ewdata, input int ewlat);
    resp_t r;
    wr_t   w;
    wait_ready();
    i_req_valid = 1'b1; i_req_store = st; i_req_funct3 = f3; i_req_addr = a; i_req_wdata = wd;
    @(posedge clock); #1;
    i_req_valid = 1'b0;
    r.rdata = erd; r.mis = emis; r.lat = elat; r.acc = cyc;
    rq.push_back(r);
    if (ewr) begin
      w.addr = ewaddr; w.data = ewdata; w.lat = ewlat; w.acc = cyc;
      wq.push_back(w);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 100) begin @(negedge clock); n++; end
    if (rq.size() != 0 || wq.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", rq.size() + wq.size());
    end
  endtask

  initial begin
    int n;
    #2 reset = 1'b1;
    #1;
    chk("rst_req_ready", {63'd0, o_req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, o_resp_valid}, 64'd0);
    chk("rst_mem_wr", {63'd0, o_mem_wr}, 64'd0);
    chk("rst_misaligned", {63'd0, o_misaligned}, 64'd0);
    chk("rst_resp_rdata", o_resp_rdata, 64'd0);
    chk("rst_mem_addr", o_mem_addr, 64'd0);
    chk("rst_mem_wdata", o_mem_wdata, 64'd0);
    #20 reset = 1'b0;

    // loads: LD, LB, LBU, LH, LW, LWU, funct3 111
    issue(0, 3'b011, 64'h10, 0, 64'h8877665544332211, 0, LAT+1, 0, 0, 0, 0);
    issue(0, 3'b000, 64'h17, 0, 64'hFFFFFFFFFFFFFF88, 0, LAT+1, 0, 0, 0, 0);
    issue(0, 3'b100, 64'h17, 0, 64'h0000000000000088, 0, LAT+1, 0, 0, 0, 0);
    issue(0, 3'b001, 64'h12, 0, 64'h0000000000004433, 0, LAT+1, 0, 0, 0, 0);
    issue(0, 3'b001, 64'h16, 0, 64'hFFFFFFFFFFFF8877, 0, LAT+1, 0, 0, 0, 0);
    issue(0, 3'b010, 64'h14, 0, 64'hFFFFFFFF88776655, 0, LAT+1, 0, 0, 0, 0);
    issue(0, 3'b110, 64'h14, 0, 64'h0000000088776655, 0, LAT+1, 0, 0, 0, 0);
    issue(0, 3'b111, 64'h10, 0, 64'h0, 0, LAT+1, 0, 0, 0, 0);

    // stores: SH RMW, SB with junk upper bits, SW with funct3[2] set, SD direct
    issue(1, 3'b001, 64'h0A, 64'hBEEF, 64'h0, 0, LAT+2, 1, 64'h08, 64'h11111111BEEF1111, LAT+1);
    issue(1, 3'b000, 64'h0B, 64'hFFFFFFA5, 64'h0, 0, LAT+2, 1, 64'h08, 64'h11111111A5EF1111, LAT+1);
    issue(1, 3'b110, 64'h0C, 64'hCAFEF00D, 64'h0, 0, LAT+2, 1, 64'h08, 64'hCAFEF00DA5EF1111, LAT+1);
    issue(0, 3'b011, 64'h08, 0, 64'hCAFEF00DA5EF1111, 0, LAT+1, 0, 0, 0, 0);
    issue(1, 3'b011, 64'h20, 64'h0123456789ABCDEF, 64'h0, 0, 1, 1, 64'h20, 64'h0123456789ABCDEF, 0);
    issue(0, 3'b011, 64'h20, 0, 64'h0123456789ABCDEF, 0, LAT+1, 0, 0, 0, 0);

    // LW with a misaligned offset
`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, 3'b010, 64'h06, 0, 64'h0, 1, 0, 0, 0, 0, 0);
`else
    issue(0, 3'b010, 64'h06, 0, 64'hFFFFFFFFF0E0D0C0, 0, LAT+1, 0, 0, 0, 0);
`endif
    issue(0, 3'b010, 64'h04, 0, 64'hFFFFFFFFF0E0D0C0, 0, LAT+1, 0, 0, 0, 0);

    // result holds after completion
    issue(0, 3'b000, 64'h17, 0, 64'hFFFFFFFFFFFFFF88, 0, LAT+1, 0, 0, 0, 0);
    drain();
    repeat (3) @(negedge clock);
    chk("rdata_hold", o_resp_rdata, 64'hFFFFFFFFFFFFFF88);

    // request during RESP must not be taken
    issue(0, 3'b011, 64'h10, 0, 64'h8877665544332211, 0, LAT+1, 0, 0, 0, 0);
    n = 0;
    while (!o_resp_valid && n < 20) begin @(negedge clock); n++; end
    chk("resp_seen", {63'd0, o_resp_valid}, 64'd1);
    i_req_valid = 1'b1; i_req_store = 1'b1; i_req_funct3 = 3'b011; i_req_addr = 64'h38;
    chk("ready_in_resp", {63'd0, o_req_ready}, 64'd0);
    @(posedge clock); #1;
    chk("no_accept_in_resp", {63'd0, o_req_ready}, 64'd1);
    i_req_valid = 1'b0;
    drain();

    // reset in RD_WAIT of SW aborts the access
    wait_ready();
    i_req_valid = 1'b1; i_req_store = 1'b1; i_req_funct3 = 3'b010;
    i_req_addr = 64'h30; i_req_wdata = 64'h12345678;
    @(posedge clock); #1;
    i_req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_req_ready", {63'd0, o_req_ready}, 64'd1);
    chk("abort_mem_wr", {63'd0, o_mem_wr}, 64'd0);
    chk("abort_resp_valid", {63'd0, o_resp_valid}, 64'd0);
    #13 reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("abort_idle", {63'd0, o_req_ready}, 64'd1);
    chk("pending_empty", 64'(rq.size() + wq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
